mmio_timer_bank: RTL and testbench

// - Memory-mapped bank of NUM_CHANNELS independent compare timers on the MMIO slave side of bus_interconnect.
// - Replaces the fixed single free-running timer in the SoC top level.
// - Per channel: periodic or one-shot mode, a sticky pending flag cleared by write-1-to-clear, and an interrupt enable.
// - timerInterrupt is the OR of the enabled pending flags and drives the controller / csr_unit trap path.

---
 rtl/timer_bank_pkg.sv | 24 ++
 rtl/timer_channel.sv | 79 +++++++
 rtl/mmio_timer_bank.sv | 131 +++++++++++++
 tb/tb_mmio_timer_bank.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_bank_pkg.sv
// Register map offsets, control-word layout and the channel address helper
// shared by the timer bank and its channels.
package timer_bank_pkg;

    localparam logic [7:0] CTRL_OFFSET     = 8'h00;
    localparam logic [7:0] COMPARE_OFFSET  = 8'h04;
    localparam logic [7:0] COUNT_OFFSET    = 8'h08;
    localparam logic [7:0] STATUS_OFFSET   = 8'h0C;
    localparam logic [7:0] PENDING_OFFSET  = 8'h80;
    localparam logic [7:0] PRESCALE_OFFSET = 8'h84;
    localparam int         CHANNEL_STRIDE  = 16;

    typedef struct packed {
        logic irqEnable;
        logic periodic;
        logic enable;
    } timer_ctrl_t;

    // Window-relative byte offset of one register inside a channel block.
    function automatic logic [7:0] channelOffset(input int channel, input logic [7:0] regOffset);
        return 8'(channel * CHANNEL_STRIDE) + regOffset;
    endfunction

endpackage

// File: rtl/timer_channel.sv
// One compare timer: CTRL/COMPARE/COUNT/pending, fire detection and bus-vs-timer priority.
// Register updates land on the edge after the write or tick; writes are always accepted.
module timer_channel
    import timer_bank_pkg::*;
#(
    parameter int COUNTER_WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     resetActiveLow,
    input  logic                     tick,
    input  logic                     ctrlWrite,
    input  logic                     compareWrite,
    input  logic                     countWrite,
    input  logic                     statusWrite,
    input  logic [31:0]              writeData,
    output timer_ctrl_t              ctrl,
    output logic [COUNTER_WIDTH-1:0] compare,
    output logic [COUNTER_WIDTH-1:0] count,
    output logic                     pending
);

    logic                     fire;
    logic                     reachedCompare;
    logic [COUNTER_WIDTH-1:0] writeValue;
    logic                     unusedWriteBits;

    assign writeValue      = writeData[COUNTER_WIDTH-1:0];
    assign unusedWriteBits = ^writeData;
    assign reachedCompare  = (count >= compare);
    assign fire            = ctrl.enable && tick && reachedCompare;

    // A CTRL write overrides the one-shot self-disable issued on the same edge.
    always_ff @(posedge clock or negedge resetActiveLow) begin
        if (!resetActiveLow) begin
            ctrl <= '0;
        end else if (ctrlWrite) begin
            ctrl <= timer_ctrl_t'(writeData[2:0]);
        end else if (fire && !ctrl.periodic) begin
            ctrl.enable <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetActiveLow) begin
        if (!resetActiveLow) begin
            compare <= '0;
        end else if (compareWrite) begin
            compare <= writeValue;
        end
    end

    // Software writes to COUNT win over both the increment and the periodic reload.
    always_ff @(posedge clock or negedge resetActiveLow) begin
        if (!resetActiveLow) begin
            count <= '0;
        end else if (countWrite) begin
            count <= writeValue;
        end else if (ctrl.enable && tick) begin
            if (reachedCompare) begin
                if (ctrl.periodic) begin
                    count <= '0;
                end
            end else begin
                count <= count + COUNTER_WIDTH'(1);
            end
        end
    end

    // A fresh fire wins over a same-cycle write-1-to-clear.
    always_ff @(posedge clock or negedge resetActiveLow) begin
        if (!resetActiveLow) begin
            pending <= 1'b0;
        end else if (fire) begin
            pending <= 1'b1;
        end else if (statusWrite && writeData[0]) begin
            pending <= 1'b0;
        end
    end

endmodule

// File: rtl/mmio_timer_bank.sv
// MMIO bank of NUM_CHANNELS compare timers with W1C pending flags and a shared interrupt line.
// Writes take effect on the next edge, reads are combinational; writes are never back-pressured.
// Optional shared prescaler is built only when TIMER_BANK_PRESCALER_EN is defined.
module mmio_timer_bank
    import timer_bank_pkg::*;
#(
    parameter int          NUM_CHANNELS     = 4,
    parameter int          COUNTER_WIDTH    = 32,
    parameter logic [31:0] BASE_ADDRESS     = 32'h40000100,
    parameter logic [15:0] PRESCALE_DEFAULT = 16'd0
) (
    input  logic                    clock,
    input  logic                    resetActiveLow,
    input  logic [31:0]             busWriteAddress,
    input  logic                    busWriteValid,
    input  logic [31:0]             busWriteData,
    input  logic [31:0]             busReadAddress,
    output logic [31:0]             busReadData,
    output logic [NUM_CHANNELS-1:0] channelPending,
    output logic                    timerInterrupt
);

    logic                     writeHit;
    logic                     readHit;
    logic [7:0]               writeOffset;
    logic [7:0]               readOffset;
    logic                     tick;
    logic [15:0]              prescaleValue;
    timer_ctrl_t              ctrlVec    [NUM_CHANNELS];
    logic [COUNTER_WIDTH-1:0] compareVec [NUM_CHANNELS];
    logic [COUNTER_WIDTH-1:0] countVec   [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]  pendingVec;
    logic [NUM_CHANNELS-1:0]  irqEnableVec;

    assign writeHit    = busWriteValid && (busWriteAddress[31:8] == BASE_ADDRESS[31:8]);
    assign readHit     = (busReadAddress[31:8] == BASE_ADDRESS[31:8]);
    assign writeOffset = busWriteAddress[7:0];
    assign readOffset  = busReadAddress[7:0];

    for (genvar n = 0; n < NUM_CHANNELS; n++) begin : gChannel
        logic ctrlWrite;
        logic compareWrite;
        logic countWrite;
        logic statusWrite;

        assign ctrlWrite    = writeHit && (writeOffset == channelOffset(n, CTRL_OFFSET));
        assign compareWrite = writeHit && (writeOffset == channelOffset(n, COMPARE_OFFSET));
        assign countWrite   = writeHit && (writeOffset == channelOffset(n, COUNT_OFFSET));
        assign statusWrite  = writeHit && (writeOffset == channelOffset(n, STATUS_OFFSET));

        timer_channel #(
            .COUNTER_WIDTH(COUNTER_WIDTH)
        ) uChannel (
            .clock         (clock),
            .resetActiveLow(resetActiveLow),
            .tick          (tick),
            .ctrlWrite     (ctrlWrite),
            .compareWrite  (compareWrite),
            .countWrite    (countWrite),
            .statusWrite   (statusWrite),
            .writeData     (busWriteData),
            .ctrl          (ctrlVec[n]),
            .compare       (compareVec[n]),
            .count         (countVec[n]),
            .pending       (pendingVec[n])
        );

        assign irqEnableVec[n] = ctrlVec[n].irqEnable;
    end

`ifdef TIMER_BANK_PRESCALER_EN
    logic [15:0] prescaleCount;
    logic        prescaleWrite;
    logic        anyEnabled;

    always_comb begin
        anyEnabled = 1'b0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            anyEnabled = anyEnabled | ctrlVec[i].enable;
        end
    end

    assign prescaleWrite = writeHit && (writeOffset == PRESCALE_OFFSET);
    assign tick          = anyEnabled && (prescaleCount == prescaleValue);

    // The divider idles while every channel is off so the first tick is a full period away.
    always_ff @(posedge clock or negedge resetActiveLow) begin
        if (!resetActiveLow) begin
            prescaleValue <= PRESCALE_DEFAULT;
            prescaleCount <= '0;
        end else if (prescaleWrite) begin
            prescaleValue <= busWriteData[15:0];
            prescaleCount <= '0;
        end else if (anyEnabled) begin
            prescaleCount <= (prescaleCount == prescaleValue) ? 16'd0 : prescaleCount + 16'd1;
        end
    end
`else
    logic [15:0] unusedPrescaleDefault;

    assign unusedPrescaleDefault = PRESCALE_DEFAULT;
    assign tick                  = 1'b1;
    assign prescaleValue         = '0;
`endif

    always_comb begin
        busReadData = '0;
        if (readHit) begin
            if (readOffset == PENDING_OFFSET) begin
                busReadData = 32'(pendingVec);
            end else if (readOffset == PRESCALE_OFFSET) begin
                busReadData = 32'(prescaleValue);
            end
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (readOffset == channelOffset(i, CTRL_OFFSET)) begin
                    busReadData = 32'(ctrlVec[i]);
                end else if (readOffset == channelOffset(i, COMPARE_OFFSET)) begin
                    busReadData = 32'(compareVec[i]);
                end else if (readOffset == channelOffset(i, COUNT_OFFSET)) begin
                    busReadData = 32'(countVec[i]);
                end else if (readOffset == channelOffset(i, STATUS_OFFSET)) begin
                    busReadData = 32'(pendingVec[i]);
                end
            end
        end
    end

    assign channelPending = pendingVec;
    assign timerInterrupt = |(pendingVec & irqEnableVec);

endmodule

// File: tb/tb_mmio_timer_bank.sv
// Directed register/timing scenarios followed by random MMIO traffic checked against
// a behavioural model of the timer bank (8-bit counters, 4 channels).
module tb_mmio_timer_bank;

    localparam int          NCH   = 4;
    localparam int          CW    = 8;
    localparam logic [31:0] BASE  = 32'h40000100;
    localparam logic [31:0] CMASK = 32'h000000FF;

    logic           clock = 1'b0;
    logic           resetActiveLow = 1'b1;
    logic [31:0]    busWriteAddress = '0;
    logic           busWriteValid = 1'b0;
    logic [31:0]    busWriteData = '0;
    logic [31:0]    busReadAddress = '0;
    logic [31:0]    busReadData;
    logic [NCH-1:0] channelPending;
    logic           timerInterrupt;

    int errors = 0;
    int checks = 0;

    mmio_timer_bank #(
        .NUM_CHANNELS (NCH),
        .COUNTER_WIDTH(CW)
    ) dut (
        .clock          (clock),
        .resetActiveLow (resetActiveLow),
        .busWriteAddress(busWriteAddress),
        .busWriteValid  (busWriteValid),
        .busWriteData   (busWriteData),
        .busReadAddress (busReadAddress),
        .busReadData    (busReadData),
        .channelPending (channelPending),
        .timerInterrupt (timerInterrupt)
    );

    always #5 clock = ~clock;

    // ---------------- behavioural reference model ----------------
    int unsigned mCount [NCH];
    int unsigned mCompare [NCH];
    bit          mEn [NCH];
    bit          mPer [NCH];
    bit          mIrq [NCH];
    bit          mPend [NCH];
    bit          mFire [NCH];
    bit          mClr [NCH];
    int unsigned mPs;
    int unsigned mPsCount;
    bit          mAny;
    bit          mTick;
    logic [31:0] mOff;
    int          mCh;

    always @(posedge clock or negedge resetActiveLow) begin
        if (!resetActiveLow) begin
            for (int i = 0; i < NCH; i++) begin
                mCount[i] = 0; mCompare[i] = 0; mEn[i] = 0;
                mPer[i] = 0; mIrq[i] = 0; mPend[i] = 0;
            end
            mPs = 0;
            mPsCount = 0;
        end else begin
            mAny = 0;
            for (int i = 0; i < NCH; i++) if (mEn[i]) mAny = 1;
`ifdef TIMER_BANK_PRESCALER_EN
            mTick = mAny && (mPsCount == mPs);
            if (mAny) mPsCount = (mPsCount == mPs) ? 0 : mPsCount + 1;
`else
            mTick = 1;
`endif
            for (int i = 0; i < NCH; i++) begin
                mClr[i]  = 0;
                mFire[i] = mEn[i] && mTick && (mCount[i] >= mCompare[i]);
                if (mEn[i] && mTick) begin
                    if (mFire[i]) begin
                        if (mPer[i]) mCount[i] = 0;
                        else         mEn[i] = 0;
                    end else begin
                        mCount[i] = mCount[i] + 1;
                    end
                end
            end
            mOff = busWriteAddress - BASE;
            if (busWriteValid && mOff < 256 && mOff[1:0] == 2'b00) begin
                if (mOff < NCH * 16) begin
                    mCh = int'(mOff / 16);
                    case (mOff % 16)
                        0: begin
                            mEn[mCh]  = busWriteData[0];
                            mPer[mCh] = busWriteData[1];
                            mIrq[mCh] = busWriteData[2];
                        end
                        4:  mCompare[mCh] = busWriteData & CMASK;
                        8:  mCount[mCh]   = busWriteData & CMASK;
                        12: mClr[mCh]     = busWriteData[0];
                        default: ;
                    endcase
                end else if (mOff == 32'h84) begin
                    mPs      = busWriteData & 32'h0000FFFF;
                    mPsCount = 0;
                end
            end
            for (int i = 0; i < NCH; i++) mPend[i] = mFire[i] || (mPend[i] && !mClr[i]);
        end
    end

    function automatic logic [NCH-1:0] modelPendVec();
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = mPend[i];
        return v;
    endfunction

    function automatic logic modelIrq();
        logic r;
        r = 1'b0;
        for (int i = 0; i < NCH; i++) r = r | (mPend[i] & mIrq[i]);
        return r;
    endfunction

    function automatic logic [31:0] modelRead(input logic [31:0] a);
        logic [31:0] off;
        logic [31:0] r;
        int          ch;
        off = a - BASE;
        r   = '0;
        if (off < 256 && off[1:0] == 2'b00) begin
            if (off < NCH * 16) begin
                ch = int'(off / 16);
                case (off % 16)
                    0:  r = {29'b0, mIrq[ch], mPer[ch], mEn[ch]};
                    4:  r = mCompare[ch];
                    8:  r = mCount[ch];
                    12: r = {31'b0, mPend[ch]};
                    default: r = '0;
                endcase
            end else if (off == 32'h80) begin
                r = 32'(modelPendVec());
`ifdef TIMER_BANK_PRESCALER_EN
            end else if (off == 32'h84) begin
                r = mPs;
`endif
            end
        end
        return r;
    endfunction

    // ---------------- helpers ----------------
    function automatic logic [31:0] chAddr(input int ch, input int r);
        return BASE + 32'(ch * 16 + r);
    endfunction

    function automatic logic [31:0] randAddr();
        logic [31:0] a;
        int          c;
        c = int'($urandom_range(0, 5));
        if (c < 5) begin
            a = chAddr(c, 4 * int'($urandom_range(0, 3)));
        end else begin
            case ($urandom_range(0, 3))
                0: a = BASE + 32'h80;
                1: a = BASE + 32'h84;
                2: a = BASE + 32'h82;
                default: a = BASE + 32'h100;
            endcase
        end
        if ($urandom_range(0, 15) == 0) a = a + 32'($urandom_range(1, 3));
        return a;
    endfunction

    function automatic logic [31:0] randData(input logic [31:0] a);
        logic [31:0] off;
        logic [31:0] d;
        off = a - BASE;
        if (off == 32'h84) return 32'($urandom_range(0, 3));
        case (off[3:0])
            4'h0: d = 32'($urandom_range(0, 7));
            4'h4, 4'h8: d = ($urandom_range(0, 7) == 0) ? $urandom() : 32'($urandom_range(0, 12));
            default: d = 32'($urandom_range(0, 3));
        endcase
        return d;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
        busWriteAddress = a;
        busWriteData    = d;
        busWriteValid   = 1'b1;
        step(1);
        busWriteValid   = 1'b0;
    endtask

    task automatic chkReg(input string tag, input logic [31:0] a, input logic [31:0] exp);
        busReadAddress = a;
        #1;
        chk(tag, busReadData, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] wa;
        logic [31:0] wd;
        int          sel;

        #2 resetActiveLow = 1'b0;
        step(2);
        resetActiveLow = 1'b1;

        // reset state
        chk("reset_pending_port", 32'(channelPending), 32'h0);
        chk("reset_irq", 32'(timerInterrupt), 32'h0);
        chkReg("reset_ctrl0", chAddr(0, 0), 32'h0);
        chkReg("reset_count0", chAddr(0, 8), 32'h0);
        chkReg("reset_compare3", chAddr(3, 4), 32'h0);
        chkReg("reset_prescale", BASE + 32'h84, 32'h0);
        step(1);

        // periodic channel 0: COMPARE=3
        busWrite(chAddr(0, 4), 32'd3);
        busWrite(chAddr(0, 0), 32'h7);
        chkReg("per_count_0", chAddr(0, 8), 32'd0);
        step(1); chkReg("per_count_1", chAddr(0, 8), 32'd1);
        step(1); chkReg("per_count_2", chAddr(0, 8), 32'd2);
        step(1); chkReg("per_count_3", chAddr(0, 8), 32'd3);
        chk("per_no_pend_yet", 32'(channelPending), 32'h0);
        step(1); chkReg("per_count_wrap", chAddr(0, 8), 32'd0);
        chk("per_pend_fire", 32'(channelPending), 32'h1);
        chk("per_irq_fire", 32'(timerInterrupt), 32'h1);

        // W1C then a clear colliding with the next fire
        busWrite(chAddr(0, 12), 32'h1);
        chk("per_w1c", 32'(channelPending), 32'h0);
        step(2);
        busWrite(chAddr(0, 12), 32'h1);
        chk("collide_w1c_fire", 32'(channelPending), 32'h1);
        chkReg("collide_count", chAddr(0, 8), 32'd0);

        // COUNT write on a tick cycle, then above-compare fires next tick
        busWrite(chAddr(0, 12), 32'h1);
        busWrite(chAddr(0, 8), 32'h10);
        chkReg("count_write_wins", chAddr(0, 8), 32'h10);
        chk("count_write_nopend", 32'(channelPending), 32'h0);
        step(1);
        chk("above_compare_fire", 32'(channelPending), 32'h1);
        chkReg("above_compare_reload", chAddr(0, 8), 32'd0);
        busWrite(chAddr(0, 0), 32'h0);
        busWrite(chAddr(0, 12), 32'h1);
        step(3);
        chkReg("disabled_frozen", chAddr(0, 8), 32'd1);
        chk("disabled_clear", 32'(channelPending), 32'h0);

        // one-shot channel 1: COMPARE=5
        busWrite(chAddr(1, 4), 32'd5);
        busWrite(chAddr(1, 0), 32'h5);
        step(5);
        chkReg("os_count_5", chAddr(1, 8), 32'd5);
        chk("os_not_yet", 32'(channelPending), 32'h0);
        step(1);
        chk("os_fire", 32'(channelPending), 32'h2);
        chkReg("os_ctrl_auto_off", chAddr(1, 0), 32'h4);
        chkReg("os_count_hold", chAddr(1, 8), 32'd5);
        busWrite(chAddr(1, 12), 32'h1);
        step(4);
        chk("os_no_refire", 32'(channelPending), 32'h0);
        chkReg("os_count_still", chAddr(1, 8), 32'd5);

        // CTRL write on the fire cycle beats the auto-disable
        busWrite(chAddr(1, 0), 32'h5);
        busWrite(chAddr(1, 0), 32'h5);
        chkReg("ctrl_write_wins", chAddr(1, 0), 32'h5);
        chk("ctrl_collide_pend", 32'(channelPending), 32'h2);
        step(1);
        chkReg("ctrl_then_off", chAddr(1, 0), 32'h4);
        busWrite(chAddr(1, 12), 32'h1);

        // masking on channel 2
        busWrite(chAddr(2, 4), 32'd2);
        busWrite(chAddr(2, 0), 32'h1);
        step(3);
        chk("mask_pend_port", 32'(channelPending), 32'h4);
        chk("mask_irq_low", 32'(timerInterrupt), 32'h0);
        chkReg("mask_pending_reg", BASE + 32'h80, 32'h4);
        chkReg("mask_misaligned_rd", BASE + 32'h82, 32'h0);
        busWrite(chAddr(2, 0), 32'h4);
        chk("mask_irq_enable", 32'(timerInterrupt), 32'h1);
        chk("mask_retained", 32'(channelPending), 32'h4);
        busWrite(chAddr(2, 12), 32'h1);
        chk("mask_irq_cleared", 32'(timerInterrupt), 32'h0);

        // decode: unmapped and misaligned accesses
        busWrite(chAddr(4, 0), 32'h7);
        busWrite(chAddr(4, 8), 32'h55);
        busWrite(BASE + 32'h6, 32'h77);
        busWrite(BASE + 32'h100, 32'h7);
        busWrite(BASE + 32'h80, 32'hF);
        chkReg("dec_compare0", chAddr(0, 4), 32'd3);
        chkReg("dec_ctrl0", chAddr(0, 0), 32'h0);
        chkReg("dec_unmapped_ch", chAddr(4, 8), 32'h0);
        chkReg("dec_other_window", BASE + 32'h100, 32'h0);
        chkReg("dec_pending_ro", BASE + 32'h80, 32'h0);
        step(1);

        // width truncation
        busWrite(chAddr(3, 8), 32'h1FF);
        chkReg("trunc_count", chAddr(3, 8), 32'hFF);
        busWrite(chAddr(3, 0), 32'hFFFFFFF8);
        chkReg("trunc_ctrl", chAddr(3, 0), 32'h0);
        step(1);

`ifdef TIMER_BANK_PRESCALER_EN
        busWrite(BASE + 32'h84, 32'd2);
        chkReg("ps_readback", BASE + 32'h84, 32'd2);
        busWrite(chAddr(0, 4), 32'd1);
        busWrite(chAddr(0, 8), 32'd0);
        busWrite(chAddr(0, 0), 32'h3);
        step(5);
        chk("ps_before_fire", 32'(channelPending), 32'h0);
        step(1);
        chk("ps_fire_6", 32'(channelPending), 32'h1);
        busWrite(chAddr(0, 12), 32'h1);
        step(4);
        chk("ps_gap", 32'(channelPending), 32'h0);
        step(1);
        chk("ps_fire_12", 32'(channelPending), 32'h1);
        busWrite(chAddr(0, 0), 32'h0);
        busWrite(chAddr(0, 12), 32'h1);
        busWrite(BASE + 32'h84, 32'd0);
`else
        busWrite(BASE + 32'h84, 32'd2);
        chkReg("ps_absent_reads0", BASE + 32'h84, 32'h0);
        step(1);
`endif

        // asynchronous reset in the middle of counting
        busWrite(chAddr(0, 0), 32'h7);
        step(1);
        #1 resetActiveLow = 1'b0;
        chkReg("arst_count0", chAddr(0, 8), 32'h0);
        chkReg("arst_ctrl0", chAddr(0, 0), 32'h0);
        chkReg("arst_compare0", chAddr(0, 4), 32'h0);
        chkReg("arst_count1", chAddr(1, 8), 32'h0);
        chk("arst_irq", 32'(timerInterrupt), 32'h0);
        step(2);
        resetActiveLow = 1'b1;
        step(2);
        chkReg("post_rst_count0", chAddr(0, 8), 32'h0);
        chk("post_rst_pend", 32'(channelPending), 32'h0);

        // random traffic against the model
        for (int k = 0; k < 400; k++) begin
            sel = int'($urandom_range(0, 9));
            wa  = randAddr();
            wd  = randData(wa);
            busWriteAddress = wa;
            busWriteData    = wd;
            busWriteValid   = (sel < 6);
            busReadAddress  = randAddr();
            step(1);
            chk("rand_read", busReadData, modelRead(busReadAddress));
            chk("rand_pending", 32'(channelPending), 32'(modelPendVec()));
            chk("rand_irq", 32'(timerInterrupt), 32'(modelIrq()));
        end
        busWriteValid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
